// File: rtl/coo_aggregate_if.sv
// coo_aggregate_if
//   Bundles the control and stream signals of the COO aggregation stage.
//   Parameters mirror coo_aggregate and must be overridden identically.
//   Signals:
//     start                          begin aggregation pass
//     in_valid/in_ready              input entry handshake
//     in_row, in_data, in_last       entry payload (lane 0 in LSBs)
//     out_valid/out_ready            aggregated row handshake
//     out_row, out_data, out_last    aggregated row payload (lane 0 in LSBs)
//     done                           pass complete
//   Modports: slave = aggregation stage, master = upstream/downstream driver.
interface coo_aggregate_if #(
    parameter int FM_WM_COLS   = 3,
    parameter int WEIGHT_WIDTH = 16,
    parameter int NUM_OF_NODES = 6,
    parameter int ROW_BW       = $clog2(NUM_OF_NODES),
    parameter int ACC_WIDTH    = WEIGHT_WIDTH + 4
) ();
    logic                               start;
    logic                               in_valid;
    logic                               in_ready;
    logic [ROW_BW-1:0]                  in_row;
    logic [FM_WM_COLS*WEIGHT_WIDTH-1:0] in_data;
    logic                               in_last;
    logic                               out_valid;
    logic                               out_ready;
    logic [ROW_BW-1:0]                  out_row;
    logic [FM_WM_COLS*ACC_WIDTH-1:0]    out_data;
    logic                               out_last;
    logic                               done;

    modport slave (
        input  start, in_valid, in_row, in_data, in_last, out_ready,
        output in_ready, out_valid, out_row, out_data, out_last, done
    );

    modport master (
        output start, in_valid, in_row, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_row, out_data, out_last, done
    );
endinterface

// File: rtl/coo_aggregate.sv
// coo_aggregate
//   Sums consecutive FM x WM rows that share a destination node row and
//   emits one aggregated row per run, flagging the final one and raising
//   done after its handshake.
//   Ports:
//     clk    clock
//     reset  synchronous, active-high reset
//     bus    coo_aggregate_if.slave (start, input stream, output stream, done)
//   Build option:
//     COO_AGG_SAT_EN  defined   -> per-lane adds saturate to ACC_WIDTH range
//                     undefined -> per-lane adds wrap modulo 2^ACC_WIDTH
module coo_aggregate #(
    parameter int FM_WM_COLS   = 3,
    parameter int WEIGHT_WIDTH = 16,
    parameter int NUM_OF_NODES = 6,
    parameter int ROW_BW       = $clog2(NUM_OF_NODES),
    parameter int ACC_WIDTH    = WEIGHT_WIDTH + 4
) (
    input  logic            clk,
    input  logic            reset,
    coo_aggregate_if.slave  bus
);

    localparam int DW = FM_WM_COLS * ACC_WIDTH;

    typedef enum logic [2:0] {IDLE, ACCUM, EMIT, FLUSH_EMIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     acc_q, acc_d;
    logic [DW-1:0]     out_reg_q, out_reg_d;
    logic [ROW_BW-1:0] cur_row_q, cur_row_d;
    logic [ROW_BW-1:0] out_row_q, out_row_d;
    logic              have_row_q, have_row_d;
    logic              last_pend_q, last_pend_d;

    logic [DW-1:0]     row_sum;
    logic [DW-1:0]     row_first;
    logic              same_row;

    function automatic logic [ACC_WIDTH-1:0] lane_add(
        input logic [ACC_WIDTH-1:0]    a,
        input logic [WEIGHT_WIDTH-1:0] b
    );
        logic [ACC_WIDTH-1:0] ext;
`ifdef COO_AGG_SAT_EN
        logic [ACC_WIDTH-1:0] s;
`endif
        ext = {{(ACC_WIDTH-WEIGHT_WIDTH){b[WEIGHT_WIDTH-1]}}, b};
`ifdef COO_AGG_SAT_EN
        s = a + ext;
        // Overflow only when both operands share a sign the sum lacks.
        if ((a[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) && (s[ACC_WIDTH-1] != a[ACC_WIDTH-1]))
            return a[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                  : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        return s;
`else
        return a + ext;
`endif
    endfunction

    function automatic logic [DW-1:0] add_row(
        input logic [DW-1:0]                      base,
        input logic [FM_WM_COLS*WEIGHT_WIDTH-1:0] data
    );
        logic [DW-1:0] res;
        res = '0;
        for (int unsigned i = 0; i < FM_WM_COLS; i++)
            res[i*ACC_WIDTH +: ACC_WIDTH] = lane_add(base[i*ACC_WIDTH +: ACC_WIDTH],
                                                     data[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
        return res;
    endfunction

    always_comb begin
        row_first = add_row('0, bus.in_data);
        row_sum   = have_row_q ? add_row(acc_q, bus.in_data) : row_first;
        same_row  = !have_row_q || (bus.in_row == cur_row_q);

        state_d     = state_q;
        acc_d       = acc_q;
        out_reg_d   = out_reg_q;
        cur_row_d   = cur_row_q;
        out_row_d   = out_row_q;
        have_row_d  = have_row_q;
        last_pend_d = last_pend_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    acc_d       = '0;
                    have_row_d  = 1'b0;
                    last_pend_d = 1'b0;
                    state_d     = ACCUM;
                end
            end
            ACCUM: begin
                if (bus.in_valid) begin
                    if (same_row) begin
                        if (!bus.in_last) begin
                            acc_d      = row_sum;
                            cur_row_d  = bus.in_row;
                            have_row_d = 1'b1;
                        end else begin
                            out_reg_d = row_sum;
                            out_row_d = bus.in_row;
                            state_d   = FLUSH_EMIT;
                        end
                    end else begin
                        // Finished run goes out; the new entry seeds the
                        // accumulator. A last entry here is flushed after.
                        out_reg_d   = acc_q;
                        out_row_d   = cur_row_q;
                        acc_d       = row_first;
                        cur_row_d   = bus.in_row;
                        last_pend_d = bus.in_last;
                        state_d     = EMIT;
                    end
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    if (last_pend_q) begin
                        out_reg_d   = acc_q;
                        out_row_d   = cur_row_q;
                        last_pend_d = 1'b0;
                        state_d     = FLUSH_EMIT;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            FLUSH_EMIT: begin
                if (bus.out_ready)
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            out_reg_q   <= '0;
            cur_row_q   <= '0;
            out_row_q   <= '0;
            have_row_q  <= 1'b0;
            last_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_reg_q   <= out_reg_d;
            cur_row_q   <= cur_row_d;
            out_row_q   <= out_row_d;
            have_row_q  <= have_row_d;
            last_pend_q <= last_pend_d;
        end
    end

    // Outputs are pure decodes of registered state and payload.
    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == EMIT) || (state_q == FLUSH_EMIT);
    assign bus.out_last  = (state_q == FLUSH_EMIT);
    assign bus.done      = (state_q == DONE);
    assign bus.out_row   = out_row_q;
    assign bus.out_data  = out_reg_q;

endmodule

// File: tb/tb_coo_aggregate.sv
// tb_coo_aggregate
//   Randomized and directed passes; expected rows come from a run-grouping
//   reference model pushed into a scoreboard, popped by an output monitor.
module tb_coo_aggregate;
    localparam int COLS = 3;
    localparam int WW   = 16;
    localparam int NN   = 6;
    localparam int RB   = $clog2(NN);
    localparam int AW   = WW + 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    coo_aggregate_if #(.FM_WM_COLS(COLS), .WEIGHT_WIDTH(WW), .NUM_OF_NODES(NN),
                       .ROW_BW(RB), .ACC_WIDTH(AW)) bus ();

    coo_aggregate #(.FM_WM_COLS(COLS), .WEIGHT_WIDTH(WW), .NUM_OF_NODES(NN),
                    .ROW_BW(RB), .ACC_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [RB-1:0]      row;
        logic [COLS*WW-1:0] data;
    } entry_t;

    typedef struct packed {
        logic [RB-1:0]      row;
        logic [COLS*AW-1:0] data;
        logic               last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reduce an exact integer sum to the accumulator's representable value.
    function automatic longint fit(longint v);
`ifdef COO_AGG_SAT_EN
        longint hi, lo;
        hi = (longint'(1) <<< (AW-1)) - 1;
        lo = -(longint'(1) <<< (AW-1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
`else
        longint m;
        m = longint'(1) <<< AW;
        v = ((v % m) + m) % m;
        if (v >= m / 2) v -= m;
        return v;
`endif
    endfunction

    function automatic void push_exp(int row, longint acc[COLS], bit last);
        exp_t x;
        x.row  = RB'(row);
        x.last = last;
        x.data = '0;
        for (int i = 0; i < COLS; i++) x.data[i*AW +: AW] = acc[i][AW-1:0];
        sb.push_back(x);
    endfunction

    // Split the pass into maximal runs of equal row; each run is one output.
    function automatic void model_pass(entry_t e[$]);
        longint acc[COLS];
        int     row = 0;
        bit     have = 0;
        for (int k = 0; k < e.size(); k++) begin
            if (have && int'(e[k].row) != row) begin
                push_exp(row, acc, 0);
                have = 0;
            end
            if (!have) for (int i = 0; i < COLS; i++) acc[i] = 0;
            for (int i = 0; i < COLS; i++)
                acc[i] = fit(acc[i] + longint'(signed'(e[k].data[i*WW +: WW])));
            row  = int'(e[k].row);
            have = 1;
        end
        push_exp(row, acc, 1);
    endfunction

    function automatic entry_t mk(int row, int l0, int l1, int l2);
        entry_t e;
        e.row  = RB'(row);
        e.data = {WW'(l2), WW'(l1), WW'(l0)};
        return e;
    endfunction

    task automatic check_all_zero(string tag);
        check({tag, "_in_ready"},  64'(bus.in_ready),  64'd0);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_out_row"},   64'(bus.out_row),   64'd0);
        check({tag, "_out_data"},  64'(bus.out_data),  64'd0);
        check({tag, "_out_last"},  64'(bus.out_last),  64'd0);
        check({tag, "_done"},      64'(bus.done),      64'd0);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("start_in_ready", 64'(bus.in_ready), 64'd1);
        check("start_done_low", 64'(bus.done), 64'd0);
    endtask

    task automatic send_entry(entry_t e, bit last);
        bit taken = 0;
        repeat ($urandom_range(0, 2)) begin
            bus.in_valid = 1'b0;
            bus.in_row   = RB'($urandom);
            bus.in_data  = (COLS*WW)'({$urandom, $urandom});
            bus.in_last  = 1'($urandom);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_row   = e.row;
        bus.in_data  = e.data;
        bus.in_last  = last;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            taken = bus.in_ready;
            @(posedge clk); #1;
            if (taken) break;
        end
        if (!taken) check("accept_timeout", 64'd0, 64'd1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (bus.done) begin seen = 1; break; end
        end
        check("done_reached", 64'(seen), 64'd1);
        check("sb_drained", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic run_pass(entry_t e[$]);
        model_pass(e);
        do_start();
        for (int k = 0; k < e.size(); k++) send_entry(e[k], k == e.size() - 1);
        wait_done();
    endtask

    // Downstream backpressure.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.out_ready = ($urandom_range(0, 99) < 60);
        end
    end

    // Output monitor.
    logic              hold_pend = 0;
    logic              done_exp  = 0;
    logic [RB-1:0]     h_row;
    logic [COLS*AW-1:0] h_data;
    logic              h_last;
    always @(negedge clk) begin
        if (reset) begin
            hold_pend = 0;
            done_exp  = 0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", 64'(bus.out_valid), 64'd1);
                check("hold_row",   64'(bus.out_row),   64'(h_row));
                check("hold_data",  64'(bus.out_data),  64'(h_data));
                check("hold_last",  64'(bus.out_last),  64'(h_last));
            end
            if (done_exp) begin
                check("done_after_last", 64'(bus.done), 64'd1);
                done_exp = 0;
            end
            if (bus.out_valid) check("in_ready_low_emit", 64'(bus.in_ready), 64'd0);
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 64'(bus.out_row), 64'hFFFF);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    check("out_row",  64'(bus.out_row),  64'(x.row));
                    check("out_data", 64'(bus.out_data), 64'(x.data));
                    check("out_last", 64'(bus.out_last), 64'(x.last));
                    if (bus.out_last) done_exp = 1;
                end
            end
            hold_pend = bus.out_valid && !bus.out_ready;
            h_row  = bus.out_row;
            h_data = bus.out_data;
            h_last = bus.out_last;
        end
    end

    initial begin
        entry_t q[$];
        int     prev;
        bit     extreme;

        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_row   = '0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;

        q = {};
        q.push_back(mk(0, 1, 2, 3));
        q.push_back(mk(0, 4, 5, 6));
        q.push_back(mk(1, 7, 8, 9));
        run_pass(q);

        q = {};
        q.push_back(mk(3, -1, -2, 5));
        run_pass(q);

        q = {};
        q.push_back(mk(2, 10, -20, 30));
        q.push_back(mk(1, 100, 200, -300));
        q.push_back(mk(2, 1, 1, 1));
        run_pass(q);

        // Abort a pass mid-accumulation; nothing from it may leak out.
        do_start();
        send_entry(mk(1, 50, 60, 70), 0);
        send_entry(mk(1, 5, 6, 7), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("abort");
        @(posedge clk); #1;
        q = {};
        q.push_back(mk(0, 2, 2, 2));
        run_pass(q);

        for (int p = 0; p < 30; p++) begin
            q = {};
            extreme = ($urandom_range(0, 3) == 0);
            prev = $urandom_range(0, NN - 1);
            for (int k = 0; k < (extreme ? 24 : $urandom_range(1, 12)); k++) begin
                entry_t e;
                if (!extreme && $urandom_range(0, 1) == 0) prev = $urandom_range(0, NN - 1);
                e.row = RB'(prev);
                for (int i = 0; i < COLS; i++)
                    e.data[i*WW +: WW] = extreme ? (($urandom_range(0, 4) == 0) ? WW'(16'h8000)
                                                                               : WW'(16'h7FFF))
                                                 : WW'($urandom);
                q.push_back(e);
            end
            run_pass(q);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
